// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and widths for the ARC4 engine sequencer
package arc4_pkg;
  localparam int KEY_W_DEF = 24;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;

  typedef enum logic [2:0] {
    IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0, PH_INIT = 2'd1, PH_KSA = 2'd2, PH_PRGA = 2'd3
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      INIT_GO, INIT_RUN: return PH_INIT;
      KSA_GO, KSA_RUN:   return PH_KSA;
      PRGA_GO, PRGA_RUN,
      DONE:              return PH_PRGA;
      default:           return PH_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/s_port_mux.sv
// rtl/s_port_mux.sv - grants the single S-RAM port to one engine by phase
module s_port_mux
  import arc4_pkg::*;
(
  input  phase_t              sel_i,
  input  logic [ADDR_W-1:0]   init_addr_i,
  input  logic [DATA_W-1:0]   init_wrdata_i,
  input  logic                init_wren_i,
  input  logic [ADDR_W-1:0]   ksa_addr_i,
  input  logic [DATA_W-1:0]   ksa_wrdata_i,
  input  logic                ksa_wren_i,
  input  logic [ADDR_W-1:0]   prga_addr_i,
  input  logic [DATA_W-1:0]   prga_wrdata_i,
  input  logic                prga_wren_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wrdata_o,
  output logic                wren_o
);
  always_comb begin
    addr_o   = '0;
    wrdata_o = '0;
    wren_o   = 1'b0;
    case (sel_i)
      PH_INIT: begin
        addr_o   = init_addr_i;
        wrdata_o = init_wrdata_i;
        wren_o   = init_wren_i;
      end
      PH_KSA: begin
        addr_o   = ksa_addr_i;
        wrdata_o = ksa_wrdata_i;
        wren_o   = ksa_wren_i;
      end
      PH_PRGA: begin
        addr_o   = prga_addr_i;
        wrdata_o = prga_wrdata_i;
        wren_o   = prga_wren_i;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/arc4_sched.sv
// rtl/arc4_sched.sv - sequences the init, KSA and PRGA engines over one S-RAM port
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic              init_en,
  input  logic              init_rdy,
  output logic              ksa_en,
  input  logic              ksa_rdy,
  output logic [KEY_W-1:0]  ksa_key,
  output logic              prga_en,
  input  logic              prga_rdy,
  output logic [KEY_W-1:0]  prga_key,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  cycles
);
  state_t           state_q, state_d;
  logic             busy_seen_q, busy_seen_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             init_en_q, init_en_d;
  logic             ksa_en_q, ksa_en_d;
  logic             prga_en_q, prga_en_d;
  phase_t           cur_phase, mux_sel;

  // An engine is only considered finished once it has been seen busy after its start pulse.
  always_comb begin
    state_d     = state_q;
    busy_seen_d = busy_seen_q;
    key_d       = key_q;
    cycles_d    = cycles_q;
    init_en_d   = 1'b0;
    ksa_en_d    = 1'b0;
    prga_en_d   = 1'b0;
    if (state_q != IDLE && cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
    case (state_q)
      IDLE: if (en) begin
        state_d     = INIT_GO;
        key_d       = key;
        cycles_d    = '0;
        busy_seen_d = 1'b0;
      end
      INIT_GO: if (init_rdy) begin
        init_en_d = 1'b1;
        state_d   = INIT_RUN;
      end
      INIT_RUN: begin
        if (!init_rdy) busy_seen_d = 1'b1;
        else if (busy_seen_q) begin
          state_d     = KSA_GO;
          busy_seen_d = 1'b0;
        end
      end
      KSA_GO: if (ksa_rdy) begin
        ksa_en_d = 1'b1;
        state_d  = KSA_RUN;
      end
      KSA_RUN: begin
        if (!ksa_rdy) busy_seen_d = 1'b1;
        else if (busy_seen_q) begin
          state_d     = PRGA_GO;
          busy_seen_d = 1'b0;
        end
      end
      PRGA_GO: if (prga_rdy) begin
        prga_en_d = 1'b1;
        state_d   = PRGA_RUN;
      end
      PRGA_RUN: begin
        if (!prga_rdy) busy_seen_d = 1'b1;
        else if (busy_seen_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_seen_q <= 1'b0;
      key_q       <= '0;
      cycles_q    <= '0;
      init_en_q   <= 1'b0;
      ksa_en_q    <= 1'b0;
      prga_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_seen_q <= busy_seen_d;
      key_q       <= key_d;
      cycles_q    <= cycles_d;
      init_en_q   <= init_en_d;
      ksa_en_q    <= ksa_en_d;
      prga_en_q   <= prga_en_d;
    end
  end

  assign rdy      = (state_q == IDLE);
  assign init_en  = init_en_q;
  assign ksa_en   = ksa_en_q;
  assign prga_en  = prga_en_q;
  assign ksa_key  = key_q;
  assign prga_key = key_q;
  assign cycles   = cycles_q;

  // DONE still reports the PRGA phase code but owns no engine, so the port is parked.
  assign cur_phase = phase_of(state_q);
  assign mux_sel   = (state_q == DONE) ? PH_IDLE : cur_phase;
  assign phase     = cur_phase;

  s_port_mux u_mux (
    .sel_i         (mux_sel),
    .init_addr_i   (init_addr),
    .init_wrdata_i (init_wrdata),
    .init_wren_i   (init_wren),
    .ksa_addr_i    (ksa_addr),
    .ksa_wrdata_i  (ksa_wrdata),
    .ksa_wren_i    (ksa_wren),
    .prga_addr_i   (prga_addr),
    .prga_wrdata_i (prga_wrdata),
    .prga_wren_i   (prga_wren),
    .addr_o        (s_addr),
    .wrdata_o      (s_wrdata),
    .wren_o        (s_wren)
  );
endmodule
